// File: rtl/vote_pkg.sv
// Shared helpers for the majority voter: popcount, default threshold and
// parameter legality.
package vote_pkg;

  localparam int MAX_N_IN = 15;
  localparam int CNT_BITS = 5;

  function automatic int default_thresh(input int n_in);
    return (n_in + 1) / 2;
  endfunction

  function automatic bit params_ok(input int n_in, input int thresh, input int hold);
    return (n_in % 2 == 1) && (n_in >= 3) && (n_in <= MAX_N_IN) &&
           (thresh >= 1) && (thresh <= n_in) && (hold >= 1);
  endfunction

  function automatic logic [CNT_BITS-1:0] popcount(input logic [MAX_N_IN-1:0] bits);
    logic [CNT_BITS-1:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < MAX_N_IN; i++) begin
      cnt = cnt + {4'd0, bits[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/vote_filter_if.sv
// Valid/ready stream carrying one data word of DW bits.
interface vote_filter_if #(
  parameter int DW = 8
) ();
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/maj_vote_bit.sv
// Threshold gate for one bit position: 1 when at least THRESH of the N_IN
// channel bits are set.
module maj_vote_bit
  import vote_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int THRESH = 2
) (
  input  logic [N_IN-1:0] i_bits,
  output logic            o_vote
);

  logic [MAX_N_IN-1:0] w_bits_ext;

  assign w_bits_ext = MAX_N_IN'(i_bits);
  assign o_vote     = (popcount(w_bits_ext) >= CNT_BITS'(THRESH));

endmodule

// File: rtl/vote_filter.sv
// N-channel bitwise majority voter with a two-stage valid/ready pipeline,
// persistence filter on the voted word and a saturating disagreement counter.
module vote_filter
  import vote_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int WIDTH  = 8,
  parameter int THRESH = default_thresh(N_IN),
  parameter int HOLD   = 4,
  parameter int CNT_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  vote_filter_if.slave     s_in,
  vote_filter_if.master    m_out,
  output logic [WIDTH-1:0] o_raw,
  output logic             o_unan,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam int RUN_W = $clog2(HOLD + 1);

  if (!params_ok(N_IN, THRESH, HOLD)) begin : g_param_check
    $error("vote_filter: illegal N_IN/THRESH/HOLD combination");
  end

  logic             w_advance;
  logic             w_unan;
  logic [WIDTH-1:0] w_vote;

  logic             r_s1_valid;
  logic             r_s1_unan;
  logic [WIDTH-1:0] r_s1_vote;

  logic             r_out_valid;
  logic             r_out_unan;
  logic [WIDTH-1:0] r_out_raw;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_filt;
  logic [RUN_W-1:0] r_run;
  logic [CNT_W-1:0] r_err_cnt;

  logic [WIDTH-1:0] w_cand_nxt;
  logic [WIDTH-1:0] w_filt_nxt;
  logic [RUN_W-1:0] w_run_nxt;
  logic [CNT_W-1:0] w_err_nxt;

  genvar b, k;
  for (b = 0; b < WIDTH; b++) begin : g_bit
    logic [N_IN-1:0] w_bits;
    for (k = 0; k < N_IN; k++) begin : g_ch
      assign w_bits[k] = s_in.data[k*WIDTH + b];
    end
    maj_vote_bit #(
      .N_IN   (N_IN),
      .THRESH (THRESH)
    ) u_maj (
      .i_bits (w_bits),
      .o_vote (w_vote[b])
    );
  end

  // Unanimity: every channel word equals channel 0.
  always_comb begin
    w_unan = 1'b1;
    for (int i = 1; i < N_IN; i++) begin
      w_unan = w_unan & (s_in.data[i*WIDTH +: WIDTH] == s_in.data[WIDTH-1:0]);
    end
  end

  // Filter and counter next-state for the sample moving from stage 1 to stage 2.
  always_comb begin
    w_cand_nxt = (r_s1_vote == r_cand) ? r_cand : r_s1_vote;
    w_run_nxt  = (r_s1_vote != r_cand)     ? RUN_W'(1) :
                 (r_run == RUN_W'(HOLD))    ? r_run     :
                                              r_run + RUN_W'(1);
    w_filt_nxt = (w_run_nxt == RUN_W'(HOLD)) ? w_cand_nxt : r_filt;
    w_err_nxt  = (!r_s1_unan && (r_err_cnt != {CNT_W{1'b1}})) ? r_err_cnt + CNT_W'(1)
                                                                : r_err_cnt;
  end

  // Pipeline, filter state and counter; bubbles only move the valid bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_unan   <= 1'b0;
      r_s1_vote   <= '0;
      r_out_valid <= 1'b0;
      r_out_unan  <= 1'b0;
      r_out_raw   <= '0;
      r_cand      <= '0;
      r_filt      <= '0;
      r_run       <= '0;
      r_err_cnt   <= '0;
    end else if (w_advance) begin
      r_s1_valid  <= s_in.valid;
      r_s1_vote   <= w_vote;
      r_s1_unan   <= w_unan;
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_raw  <= r_s1_vote;
        r_out_unan <= r_s1_unan;
        r_cand     <= w_cand_nxt;
        r_run      <= w_run_nxt;
        r_filt     <= w_filt_nxt;
        r_err_cnt  <= w_err_nxt;
      end
    end
  end

  assign w_advance   = !r_out_valid || m_out.ready;
  assign s_in.ready  = w_advance;
  assign m_out.valid = r_out_valid;
  assign m_out.data  = r_filt;
  assign o_raw       = r_out_raw;
  assign o_unan      = r_out_unan;
  assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_vote_filter.sv
// Randomised bench for vote_filter against a word-level reference model;
// a second instance with a 4-bit counter exercises saturation.
module tb_vote_filter;

  localparam int N_IN = 3, WIDTH = 8, HOLD = 4, THRESH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        tb_in_valid;
  logic [23:0] tb_in_data;
  logic        tb_out_ready;

  always #5 clk = ~clk;

  vote_filter_if #(.DW(24)) in_a ();
  vote_filter_if #(.DW(8))  out_a ();
  vote_filter_if #(.DW(24)) in_b ();
  vote_filter_if #(.DW(8))  out_b ();

  assign in_a.valid  = tb_in_valid;
  assign in_a.data   = tb_in_data;
  assign out_a.ready = tb_out_ready;
  assign in_b.valid  = tb_in_valid;
  assign in_b.data   = tb_in_data;
  assign out_b.ready = tb_out_ready;

  logic [7:0]  raw_a, raw_b;
  logic        unan_a, unan_b;
  logic [15:0] err_a;
  logic [3:0]  err_b;

  vote_filter #(.N_IN(3), .WIDTH(8), .HOLD(4), .CNT_W(16)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .s_in(in_a), .m_out(out_a),
    .o_raw(raw_a), .o_unan(unan_a), .o_err_cnt(err_a));

  vote_filter #(.N_IN(3), .WIDTH(8), .HOLD(4), .CNT_W(4)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .s_in(in_b), .m_out(out_b),
    .o_raw(raw_b), .o_unan(unan_b), .o_err_cnt(err_b));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: accepted samples in order, last HOLD votes, committed word.
  logic [23:0] exp_q[$];
  logic [7:0]  hist[$];
  logic [7:0]  exp_filt = 8'h00;
  int          nonunan  = 0;
  int          cyc      = 0;
  int          first_acc = -1, first_out = -1;
  int          stall_left = 0;
  logic        stall_prev = 1'b0;
  logic [7:0]  prev_data, prev_raw;
  logic        prev_unan;
  logic [15:0] prev_err;

  function automatic logic [7:0] ref_vote(input logic [23:0] s);
    logic [7:0] v;
    for (int b = 0; b < WIDTH; b++) begin
      int ones = 0;
      for (int k = 0; k < N_IN; k++) ones += int'(s[k*WIDTH + b]);
      v[b] = (ones >= THRESH);
    end
    return v;
  endfunction

  function automatic logic ref_unan(input logic [23:0] s);
    return (s[7:0] == s[15:8]) && (s[15:8] == s[23:16]);
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hist.delete();
      exp_filt   = 8'h00;
      nonunan    = 0;
      stall_prev = 1'b0;
    end else begin
      chk("in_ready", {31'd0, in_a.ready}, {31'd0, (!out_a.valid || tb_out_ready)});
      chk("valid_b", {31'd0, out_b.valid}, {31'd0, out_a.valid});
      if (stall_prev) begin
        chk("hold_valid", {31'd0, out_a.valid}, 32'd1);
        chk("hold_data", {24'd0, out_a.data}, {24'd0, prev_data});
        chk("hold_raw", {24'd0, raw_a}, {24'd0, prev_raw});
        chk("hold_unan", {31'd0, unan_a}, {31'd0, prev_unan});
        chk("hold_err", {16'd0, err_a}, {16'd0, prev_err});
      end
      if (out_a.valid && first_out < 0) first_out = cyc;
      if (out_a.valid && tb_out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 32'd1, 32'd0);
        end else begin
          logic [23:0] s;
          logic [7:0]  v;
          logic        same;
          s = exp_q.pop_front();
          v = ref_vote(s);
          hist.push_back(v);
          if (hist.size() > HOLD) void'(hist.pop_front());
          same = (hist.size() == HOLD);
          foreach (hist[i]) same = same && (hist[i] == v);
          if (same) exp_filt = v;
          if (!ref_unan(s)) nonunan++;
          chk("out_data", {24'd0, out_a.data}, {24'd0, exp_filt});
          chk("out_raw", {24'd0, raw_a}, {24'd0, v});
          chk("out_unan", {31'd0, unan_a}, {31'd0, ref_unan(s)});
          chk("err_cnt", {16'd0, err_a}, nonunan);
          chk("err_cnt_sat", {28'd0, err_b}, (nonunan > 15) ? 32'd15 : nonunan);
        end
      end
      if (tb_in_valid && in_a.ready) begin
        exp_q.push_back(tb_in_data);
        if (first_acc < 0) first_acc = cyc;
      end
      stall_prev = out_a.valid && !tb_out_ready;
      prev_data  = out_a.data;
      prev_raw   = raw_a;
      prev_unan  = unan_a;
      prev_err   = err_a;
    end
  end

  // Offer one sample until accepted; out_ready random with rdy_pct% chance of 1.
  task automatic send(input logic [23:0] s, input int rdy_pct);
    logic took;
    int   guard = 0;
    tb_in_valid = 1'b1;
    tb_in_data  = s;
    do begin
      if (stall_left > 0) begin
        tb_out_ready = 1'b0;
        stall_left--;
      end else begin
        tb_out_ready = ($urandom_range(99) < rdy_pct);
      end
      @(negedge clk);
      took = in_a.ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!took && guard < 500);
    if (!took) chk("send_timeout", 32'd0, 32'd1);
    tb_in_valid = 1'b0;
  endtask

  task automatic idle(input int n, input int rdy_pct);
    tb_in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      tb_out_ready = ($urandom_range(99) < rdy_pct);
      @(posedge clk);
      #1;
    end
  endtask

  logic [7:0] last_base = 8'hA5;

  function automatic logic [23:0] rnd_sample();
    logic [23:0] s;
    if ($urandom_range(99) >= 60) begin
      case ($urandom_range(3))
        0:       last_base = 8'hA5;
        1:       last_base = 8'h3C;
        2:       last_base = 8'h00;
        default: last_base = 8'($urandom);
      endcase
    end
    for (int k = 0; k < N_IN; k++)
      s[k*8 +: 8] = ($urandom_range(9) < 7) ? last_base : 8'($urandom);
    return s;
  endfunction

  initial begin
    rst          = 1'b1;
    tb_in_valid  = 1'b0;
    tb_in_data   = 24'd0;
    tb_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'd0, out_a.valid}, 32'd0);
    chk("rst_data", {24'd0, out_a.data}, 32'd0);
    chk("rst_raw", {24'd0, raw_a}, 32'd0);
    chk("rst_unan", {31'd0, unan_a}, 32'd0);
    chk("rst_err", {16'd0, err_a}, 32'd0);
    chk("rst_in_ready", {31'd0, in_a.ready}, 32'd1);
    @(posedge clk);
    #1;

    // Commit after four identical votes, latency 2.
    first_acc = -1;
    first_out = -1;
    repeat (4) send(24'hA5A5A5, 100);
    idle(4, 100);
    chk("latency", first_out - first_acc, 32'd2);

    // One disagreeing sample, then re-commit A5 and toggle through 5A.
    send(24'hF00F0F, 100);
    repeat (4) send(24'hA5A5A5, 100);
    send(24'hA5A5A5, 100);
    send(24'h5A5A5A, 100);
    send(24'hA5A5A5, 100);
    idle(4, 100);
    chk("t3_data", {24'd0, out_a.data}, 32'h0000_00A5);

    // Three-cycle stall in the middle of a continuous stream.
    repeat (3) send(24'h3C3C3C, 100);
    stall_left = 3;
    repeat (5) send(24'h3C3C3C, 100);
    idle(4, 100);

    // Counter saturation on the 4-bit instance.
    repeat (20) send(24'hF00F0F, 100);
    idle(4, 100);
    chk("t5_err_b", {28'd0, err_b}, 32'd15);

    // Reset while stalled with a word present.
    repeat (2) send(24'h123456, 100);
    tb_out_ready = 1'b0;
    @(negedge clk);
    chk("t6_pre_valid", {31'd0, out_a.valid}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_valid", {31'd0, out_a.valid}, 32'd0);
    chk("t6_err", {16'd0, err_a}, 32'd0);
    chk("t6_err_b", {28'd0, err_b}, 32'd0);
    @(posedge clk);
    #1;
    repeat (4) send(24'h3C3C3C, 100);
    idle(4, 100);
    chk("t6_commit", {24'd0, out_a.data}, 32'h0000_003C);

    // Random traffic with backpressure and bubbles.
    for (int i = 0; i < 600; i++) begin
      send(rnd_sample(), 70);
      if ($urandom_range(99) < 30) idle($urandom_range(2), 70);
    end
    idle(8, 100);
    chk("drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
